// File: rtl/blind_pkg.sv
// -----------------------------------------------------------------------------
// blind_pkg
// Shared definitions for the automatic blind controller.
//   - Position command codes, shared with the blind-position FSM.
//   - State encoding of the motor driver FSM.
// -----------------------------------------------------------------------------
package blind_pkg;

  typedef logic [1:0] pos_code_t;

  localparam pos_code_t POS_CLOSED = 2'b00;
  localparam pos_code_t POS_HALF   = 2'b01;
  localparam pos_code_t POS_OPEN   = 2'b10;
  localparam pos_code_t POS_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    ST_HOME  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_UP    = 3'd2,
    ST_DN    = 3'd3,
    ST_IDLE  = 3'd4,
    ST_FAULT = 3'd5
  } drv_state_t;

endpackage

// File: rtl/blind_motor_driver_if.sv
// -----------------------------------------------------------------------------
// blind_motor_driver_if
// Signal bundle between the blind controller / field wiring and the motor
// driver.
//   master : drives target, tick, lim_top, lim_bot; observes driver outputs
//   slave  : the motor driver itself
// Signals:
//   target    commanded position code (closed / half / open / hold)
//   tick      encoder step pulse, one clk wide
//   lim_top   raw top limit switch, active-high
//   lim_bot   raw bottom limit switch, active-high
//   mot_up    raise relay
//   mot_dn    lower relay
//   pos       current position in encoder steps
//   at_target motor idle and pos equals the goal
//   fault     sticky stall fault
// -----------------------------------------------------------------------------
interface blind_motor_driver_if
  import blind_pkg::*;
#(
  parameter int POS_W = 8
) ();

  pos_code_t        target;
  logic             tick;
  logic             lim_top;
  logic             lim_bot;
  logic             mot_up;
  logic             mot_dn;
  logic [POS_W-1:0] pos;
  logic             at_target;
  logic             fault;

  modport master (
    output target, tick, lim_top, lim_bot,
    input  mot_up, mot_dn, pos, at_target, fault
  );

  modport slave (
    input  target, tick, lim_top, lim_bot,
    output mot_up, mot_dn, pos, at_target, fault
  );

endinterface

// File: rtl/blind_motor_driver_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a raw asynchronous level input.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset (output clears to 0)
//   d_i    raw asynchronous input
//   q_o    synchronized output, 2 clk of latency
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/blind_motor_driver.sv
// -----------------------------------------------------------------------------
// blind_motor_driver
// Drives the up/down relays of a blind motor until the encoder position
// matches the commanded position. Homes against the bottom limit after reset,
// keeps both relays off for a dead time before every start, and latches a
// fault if the encoder stops stepping while the motor runs.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; relays drop immediately
//   bus    slave side of blind_motor_driver_if (target, tick, limits in;
//          relays, pos, at_target, fault out)
// -----------------------------------------------------------------------------
module blind_motor_driver
  import blind_pkg::*;
#(
  parameter int TRAVEL_TICKS   = 200,
  parameter int HALF_TICKS     = 100,
  parameter int DEAD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  blind_motor_driver_if.slave    bus
);

  localparam int POS_W = $clog2(TRAVEL_TICKS + 1);
  localparam int DC_W  = $clog2(DEAD_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [POS_W-1:0] GOAL_TOP  = POS_W'(TRAVEL_TICKS);
  localparam logic [POS_W-1:0] GOAL_HALF = POS_W'(HALF_TICKS);
  localparam logic [DC_W-1:0]  DC_LAST   = DC_W'(DEAD_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  drv_state_t       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DC_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             mot_up_q, mot_dn_q, at_target_q, fault_q;

  logic             lim_top_s, lim_bot_s;
  logic [POS_W-1:0] goal;
  logic             stall;
  logic             dead_done;
  logic             run_d;

  sync2 u_sync_top (.clk(clk), .reset(reset), .d_i(bus.lim_top), .q_o(lim_top_s));
  sync2 u_sync_bot (.clk(clk), .reset(reset), .d_i(bus.lim_bot), .q_o(lim_bot_s));

  // Position update comes first so that the goal comparison below always
  // sees a tick that arrives in the same cycle as a target change.
  always_comb begin
    pos_d = pos_q;
    case (state_q)
      ST_UP: begin
        if (lim_top_s)                          pos_d = GOAL_TOP;
        else if (bus.tick && pos_q != GOAL_TOP) pos_d = pos_q + 1'b1;
      end
      ST_DN: begin
        if (lim_bot_s)                          pos_d = '0;
        else if (bus.tick && pos_q != '0)       pos_d = pos_q - 1'b1;
      end
      ST_HOME: begin
        if (lim_bot_s)                          pos_d = '0;
      end
      default: ;
    endcase
  end

  // Hold freezes the goal at wherever the blind is, which makes every
  // running state fall into its normal stop path.
  always_comb begin
    goal = pos_d;
    case (bus.target)
      POS_CLOSED: goal = '0;
      POS_HALF:   goal = GOAL_HALF;
      POS_OPEN:   goal = GOAL_TOP;
      default:    goal = pos_d;
    endcase
  end

  assign stall     = !bus.tick && (wdog_q == WD_LAST);
  assign dead_done = (dead_cnt_q == DC_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOME: begin
        if (lim_bot_s)  state_d = ST_DEAD;
        else if (stall) state_d = ST_FAULT;
      end
      ST_IDLE: begin
        if (goal != pos_d) state_d = ST_DEAD;
      end
      ST_DEAD: begin
        // Direction is chosen fresh at expiry; the goal may have moved.
        if (dead_done) begin
          if (goal > pos_d)      state_d = ST_UP;
          else if (goal < pos_d) state_d = ST_DN;
          else                   state_d = ST_IDLE;
        end
      end
      ST_UP: begin
        if (lim_top_s || pos_d >= goal) state_d = ST_DEAD;
        else if (stall)                 state_d = ST_FAULT;
      end
      ST_DN: begin
        if (lim_bot_s || pos_d <= goal) state_d = ST_DEAD;
        else if (stall)                 state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Dead counter runs only while staying in DEAD, so every visit lasts
  // exactly DEAD_CYCLES cycles.
  always_comb begin
    dead_cnt_d = '0;
    if (state_q == ST_DEAD && state_d == ST_DEAD) dead_cnt_d = dead_cnt_q + 1'b1;
  end

  // Watchdog restarts on every tick and on entry to a motor-running state.
  assign run_d = (state_d == ST_UP) || (state_d == ST_DN) || (state_d == ST_HOME);

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (!run_d || bus.tick || state_d != state_q) wdog_d = '0;
  end

  // Relay outputs are registered from the next state, so UP and DN can never
  // be driven together and every reversal carries the DEAD gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOME;
      pos_q       <= '0;
      dead_cnt_q  <= '0;
      wdog_q      <= '0;
      mot_up_q    <= 1'b0;
      mot_dn_q    <= 1'b0;
      at_target_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dead_cnt_q  <= dead_cnt_d;
      wdog_q      <= wdog_d;
      mot_up_q    <= (state_d == ST_UP);
      mot_dn_q    <= (state_d == ST_DN) || (state_d == ST_HOME);
      at_target_q <= (state_d == ST_IDLE) && (pos_d == goal);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.mot_up    = mot_up_q;
  assign bus.mot_dn    = mot_dn_q;
  assign bus.pos       = pos_q;
  assign bus.at_target = at_target_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_blind_motor_driver.sv
// -----------------------------------------------------------------------------
// tb_blind_motor_driver
// Directed scenarios for the blind motor driver: reset, homing, open, reversal,
// hold, same-direction retarget with simultaneous tick, early top limit, stall
// fault and reset during a move.
// -----------------------------------------------------------------------------
module tb_blind_motor_driver;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   both_seen = 1'b0;

  blind_motor_driver_if #(.POS_W(8)) bus_if ();

  blind_motor_driver #(
    .TRAVEL_TICKS(200),
    .HALF_TICKS(100),
    .DEAD_CYCLES(16),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.mot_up && bus_if.mot_dn) both_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.tick = 1'b1;
      step();
      bus_if.tick = 1'b0;
    end
  endtask

  // Steps until the chosen relay closes or the budget expires.
  task automatic wait_relay(input bit up, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget && !(up ? bus_if.mot_up : bus_if.mot_dn)) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (bus_if.mot_up !== 1'b0 || bus_if.mot_dn !== 1'b0) begin errors++; $display("FAIL reset_relays: up=%b dn=%b expected 0 0", bus_if.mot_up, bus_if.mot_dn); end
    checks++; if (bus_if.pos !== 8'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", bus_if.pos); end
    checks++; if (bus_if.at_target !== 1'b0 || bus_if.fault !== 1'b0) begin errors++; $display("FAIL reset_flags: at_target=%b fault=%b expected 0 0", bus_if.at_target, bus_if.fault); end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    checks++; if (bus_if.mot_dn !== 1'b1 || bus_if.mot_up !== 1'b0) begin errors++; $display("FAIL first_cycle_dn: up=%b dn=%b expected 0 1", bus_if.mot_up, bus_if.mot_dn); end
    $display("reset: mot_dn=%b pos=%0d", bus_if.mot_dn, bus_if.pos);
  endtask

  task automatic test_homing();
    int off_cnt;
    tick_n(5);
    checks++; if (bus_if.pos !== 8'd0 || bus_if.mot_dn !== 1'b1) begin errors++; $display("FAIL home_ticks: pos=%0d dn=%b expected 0 1", bus_if.pos, bus_if.mot_dn); end
    bus_if.lim_bot = 1'b1;
    step(); step();
    checks++; if (bus_if.mot_dn !== 1'b1) begin errors++; $display("FAIL home_sync_hold: dn=%b expected 1", bus_if.mot_dn); end
    step();
    checks++; if (bus_if.mot_dn !== 1'b0 || bus_if.pos !== 8'd0) begin errors++; $display("FAIL home_stop: dn=%b pos=%0d expected 0 0", bus_if.mot_dn, bus_if.pos); end
    off_cnt = 0;
    repeat (15) begin
      step();
      if (!bus_if.mot_up && !bus_if.mot_dn) off_cnt++;
    end
    checks++; if (off_cnt !== 15 || bus_if.at_target !== 1'b0) begin errors++; $display("FAIL home_dead: off=%0d at_target=%b expected 15 0", off_cnt, bus_if.at_target); end
    step();
    checks++; if (bus_if.at_target !== 1'b1) begin errors++; $display("FAIL home_at_target: got %b expected 1", bus_if.at_target); end
    $display("homing: pos=%0d at_target=%b", bus_if.pos, bus_if.at_target);
  endtask

  task automatic test_open();
    int n;
    bus_if.target = 2'b10;
    wait_relay(1'b1, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL open_start: latency=%0d expected 17", n); end
    bus_if.lim_bot = 1'b0;
    tick_n(199);
    checks++; if (bus_if.pos !== 8'd199 || bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL open_run: pos=%0d up=%b expected 199 1", bus_if.pos, bus_if.mot_up); end
    tick_n(1);
    checks++; if (bus_if.pos !== 8'd200 || bus_if.mot_up !== 1'b0) begin errors++; $display("FAIL open_stop: pos=%0d up=%b expected 200 0", bus_if.pos, bus_if.mot_up); end
    repeat (15) step();
    checks++; if (bus_if.at_target !== 1'b0) begin errors++; $display("FAIL open_at_early: got %b expected 0", bus_if.at_target); end
    step();
    checks++; if (bus_if.at_target !== 1'b1) begin errors++; $display("FAIL open_at_target: got %b expected 1", bus_if.at_target); end
    $display("open: pos=%0d at_target=%b", bus_if.pos, bus_if.at_target);
  endtask

  task automatic test_reversal();
    int n;
    int off_cnt;
    bus_if.target = 2'b00;
    wait_relay(1'b0, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL rev_close_start: latency=%0d expected 17", n); end
    tick_n(200);
    checks++; if (bus_if.pos !== 8'd0 || bus_if.mot_dn !== 1'b0) begin errors++; $display("FAIL rev_closed: pos=%0d dn=%b expected 0 0", bus_if.pos, bus_if.mot_dn); end
    repeat (16) step();
    bus_if.target = 2'b10;
    wait_relay(1'b1, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL rev_up_start: latency=%0d expected 17", n); end
    tick_n(150);
    checks++; if (bus_if.pos !== 8'd150 || bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL rev_at150: pos=%0d up=%b expected 150 1", bus_if.pos, bus_if.mot_up); end
    bus_if.target = 2'b01;
    step();
    checks++; if (bus_if.mot_up !== 1'b0 || bus_if.mot_dn !== 1'b0) begin errors++; $display("FAIL rev_drop: up=%b dn=%b expected 0 0", bus_if.mot_up, bus_if.mot_dn); end
    off_cnt = 0;
    repeat (15) begin
      step();
      if (!bus_if.mot_up && !bus_if.mot_dn) off_cnt++;
    end
    checks++; if (off_cnt !== 15) begin errors++; $display("FAIL rev_dead: off=%0d expected 15", off_cnt); end
    step();
    checks++; if (bus_if.mot_dn !== 1'b1 || bus_if.mot_up !== 1'b0) begin errors++; $display("FAIL rev_dn_on: up=%b dn=%b expected 0 1", bus_if.mot_up, bus_if.mot_dn); end
    tick_n(49);
    checks++; if (bus_if.pos !== 8'd101 || bus_if.mot_dn !== 1'b1) begin errors++; $display("FAIL rev_run: pos=%0d dn=%b expected 101 1", bus_if.pos, bus_if.mot_dn); end
    tick_n(1);
    checks++; if (bus_if.pos !== 8'd100 || bus_if.mot_dn !== 1'b0) begin errors++; $display("FAIL rev_stop: pos=%0d dn=%b expected 100 0", bus_if.pos, bus_if.mot_dn); end
    repeat (16) step();
    checks++; if (bus_if.at_target !== 1'b1) begin errors++; $display("FAIL rev_at_target: got %b expected 1", bus_if.at_target); end
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL interlock: both relays seen high=%b expected 0", both_seen); end
    $display("reversal: pos=%0d at_target=%b", bus_if.pos, bus_if.at_target);
  endtask

  task automatic test_hold();
    int n;
    bus_if.target = 2'b00;
    wait_relay(1'b0, 40, n);
    tick_n(100);
    repeat (16) step();
    bus_if.target = 2'b10;
    wait_relay(1'b1, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL hold_start: latency=%0d expected 17", n); end
    tick_n(60);
    checks++; if (bus_if.pos !== 8'd60 || bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL hold_at60: pos=%0d up=%b expected 60 1", bus_if.pos, bus_if.mot_up); end
    bus_if.target = 2'b11;
    step();
    checks++; if (bus_if.mot_up !== 1'b0 || bus_if.pos !== 8'd60) begin errors++; $display("FAIL hold_stop: up=%b pos=%0d expected 0 60", bus_if.mot_up, bus_if.pos); end
    repeat (16) step();
    checks++; if (bus_if.at_target !== 1'b1 || bus_if.pos !== 8'd60) begin errors++; $display("FAIL hold_at_target: at=%b pos=%0d expected 1 60", bus_if.at_target, bus_if.pos); end
    repeat (20) step();
    checks++; if (bus_if.at_target !== 1'b1 || bus_if.mot_up !== 1'b0 || bus_if.mot_dn !== 1'b0) begin errors++; $display("FAIL hold_stay: at=%b up=%b dn=%b expected 1 0 0", bus_if.at_target, bus_if.mot_up, bus_if.mot_dn); end
    $display("hold: pos=%0d at_target=%b", bus_if.pos, bus_if.at_target);
  endtask

  task automatic test_retarget();
    int n;
    bus_if.target = 2'b01;
    wait_relay(1'b1, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL retarget_start: latency=%0d expected 17", n); end
    tick_n(39);
    checks++; if (bus_if.pos !== 8'd99) begin errors++; $display("FAIL retarget_pos99: got %0d expected 99", bus_if.pos); end
    bus_if.tick   = 1'b1;
    bus_if.target = 2'b10;
    step();
    bus_if.tick   = 1'b0;
    checks++; if (bus_if.pos !== 8'd100 || bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL retarget_continue: pos=%0d up=%b expected 100 1", bus_if.pos, bus_if.mot_up); end
    tick_n(90);
    checks++; if (bus_if.pos !== 8'd190 || bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL retarget_at190: pos=%0d up=%b expected 190 1", bus_if.pos, bus_if.mot_up); end
    $display("retarget: pos=%0d mot_up=%b", bus_if.pos, bus_if.mot_up);
  endtask

  task automatic test_early_limit();
    bus_if.lim_top = 1'b1;
    step(); step();
    checks++; if (bus_if.mot_up !== 1'b1) begin errors++; $display("FAIL limit_sync_hold: up=%b expected 1", bus_if.mot_up); end
    step();
    checks++; if (bus_if.mot_up !== 1'b0 || bus_if.pos !== 8'd200) begin errors++; $display("FAIL limit_stop: up=%b pos=%0d expected 0 200", bus_if.mot_up, bus_if.pos); end
    repeat (16) step();
    checks++; if (bus_if.at_target !== 1'b1) begin errors++; $display("FAIL limit_at_target: got %b expected 1", bus_if.at_target); end
    bus_if.lim_top = 1'b0;
    $display("early_limit: pos=%0d at_target=%b", bus_if.pos, bus_if.at_target);
  endtask

  task automatic test_stall();
    int n;
    bus_if.target = 2'b00;
    wait_relay(1'b0, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL stall_start: latency=%0d expected 17", n); end
    repeat (4095) step();
    checks++; if (bus_if.fault !== 1'b0 || bus_if.mot_dn !== 1'b1) begin errors++; $display("FAIL stall_early: fault=%b dn=%b expected 0 1", bus_if.fault, bus_if.mot_dn); end
    step();
    checks++; if (bus_if.fault !== 1'b1 || bus_if.mot_dn !== 1'b0 || bus_if.mot_up !== 1'b0) begin errors++; $display("FAIL stall_fault: fault=%b up=%b dn=%b expected 1 0 0", bus_if.fault, bus_if.mot_up, bus_if.mot_dn); end
    bus_if.target = 2'b10;
    repeat (40) step();
    tick_n(3);
    checks++; if (bus_if.fault !== 1'b1 || bus_if.mot_up !== 1'b0 || bus_if.pos !== 8'd200) begin errors++; $display("FAIL stall_sticky: fault=%b up=%b pos=%0d expected 1 0 200", bus_if.fault, bus_if.mot_up, bus_if.pos); end
    $display("stall: fault=%b pos=%0d", bus_if.fault, bus_if.pos);
  endtask

  task automatic test_reset_mid_move();
    reset = 1'b1;
    #1;
    checks++; if (bus_if.fault !== 1'b0 || bus_if.pos !== 8'd0) begin errors++; $display("FAIL rst_clear: fault=%b pos=%0d expected 0 0", bus_if.fault, bus_if.pos); end
    @(posedge clk); #1;
    reset = 1'b0;
    step(); step();
    checks++; if (bus_if.mot_dn !== 1'b1) begin errors++; $display("FAIL rst_rehome: dn=%b expected 1", bus_if.mot_dn); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (bus_if.mot_dn !== 1'b0 || bus_if.mot_up !== 1'b0) begin errors++; $display("FAIL rst_async_drop: up=%b dn=%b expected 0 0", bus_if.mot_up, bus_if.mot_dn); end
    $display("reset_mid_move: mot_dn=%b fault=%b", bus_if.mot_dn, bus_if.fault);
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.target  = 2'b00;
    bus_if.tick    = 1'b0;
    bus_if.lim_top = 1'b0;
    bus_if.lim_bot = 1'b0;
    test_reset();
    test_homing();
    test_open();
    test_reversal();
    test_hold();
    test_retarget();
    test_early_limit();
    test_stall();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
